// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared across the 16-bit CPU datapath.
//   - DATA_W            : datapath width
//   - WB_ALU..WB_IMM    : writeback source indices
//   - occ_state_e       : occupancy state of 2-entry skid buffers
package cpu_pkg;

   localparam int unsigned DATA_W = 16;

   localparam int unsigned WB_ALU  = 0;
   localparam int unsigned WB_MEM  = 1;
   localparam int unsigned WB_LINK = 2;
   localparam int unsigned WB_IMM  = 3;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_e;

endpackage

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: generic 2-entry valid/ready skid buffer.
// Ports:
//   clk_i        rising-edge clock
//   reset_ni     synchronous active-low reset (discards all entries)
//   in_data_i    payload from upstream
//   in_valid_i   upstream offers a payload
//   in_ready_o   buffer accepts this cycle (registered, no path from out_ready_i)
//   out_data_o   head-of-queue payload (main register)
//   out_valid_o  head entry present (registered)
//   out_ready_i  downstream takes the head entry
module wb_skid_buf
   import cpu_pkg::*;
#(
   parameter int unsigned PW = 21
) (
   input  logic          clk_i,
   input  logic          reset_ni,
   input  logic [PW-1:0] in_data_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   output logic [PW-1:0] out_data_o,
   output logic          out_valid_o,
   input  logic          out_ready_i
);

   occ_state_e    state_q, state_d;
   logic [PW-1:0] m_q, m_d;
   logic [PW-1:0] s_q, s_d;
   logic          in_ready_q, in_ready_d;
   logic          accept, drain;

   assign accept = in_valid_i & in_ready_q;
   assign drain  = (state_q != ST_EMPTY) & out_ready_i;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               m_d     = in_data_i;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               m_d = in_data_i;
            end else if (accept) begin
               s_d     = in_data_i;
               state_d = ST_FULL;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only the skid entry can move
            if (drain) begin
               m_d     = s_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // ready is computed from the next state so it can be registered
      in_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q    <= ST_EMPTY;
         m_q        <= '0;
         s_q        <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         s_q        <= s_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_data_o  = m_q;
   assign out_valid_o = (state_q != ST_EMPTY);

endmodule

// File: rtl/wb_select_pipe.sv
// wb_select_pipe: writeback-select stage. Picks one of NSRC result sources,
// registers it with its destination address / write enable, and hands it to
// the register file through a valid/ready handshake backed by wb_skid_buf.
// Ports:
//   clk, reset (sync, active-low)
//   src_data     flattened sources, source i at [i*WIDTH +: WIDTH]
//   sel          source select; out-of-range selects source 0 (ALU)
//   in_wr_addr, in_wr_en, in_valid / in_ready   upstream side
//   out_data, out_wr_addr, out_wr_en, out_valid / out_ready   downstream side
//   ld_byte, ld_hi, ld_signed   byte-load extract (only with WB_BYTE_LOAD_EN)
// Optional feature macro: WB_BYTE_LOAD_EN
module wb_select_pipe
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH   = DATA_W,
   parameter int unsigned NSRC    = 4,
   parameter int unsigned SELW    = 2,
   parameter int unsigned AW      = 4,
   parameter int unsigned MEM_SRC = WB_MEM
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic [SELW-1:0]      sel,
   input  logic [AW-1:0]        in_wr_addr,
   input  logic                 in_wr_en,
   input  logic                 in_valid,
   output logic                 in_ready,
`ifdef WB_BYTE_LOAD_EN
   input  logic                 ld_byte,
   input  logic                 ld_hi,
   input  logic                 ld_signed,
`endif
   output logic [WIDTH-1:0]     out_data,
   output logic [AW-1:0]        out_wr_addr,
   output logic                 out_wr_en,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned PW = WIDTH + AW + 1;

   logic [WIDTH-1:0] sel_value;
   logic [WIDTH-1:0] wb_value;
   logic             mem_sel;
   logic             byte_mode, byte_hi, byte_sext;
   logic [7:0]       byte_val;
   logic [PW-1:0]    pl_in, pl_out;
   logic             pl_we;

   always_comb begin
      sel_value = src_data[WB_ALU*WIDTH +: WIDTH];
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (sel == SELW'(i)) sel_value = src_data[i*WIDTH +: WIDTH];
      end
   end

`ifdef WB_BYTE_LOAD_EN
   assign byte_mode = ld_byte;
   assign byte_hi   = ld_hi;
   assign byte_sext = ld_signed;
`else
   // extract path is tied off; memory data passes through unchanged
   assign byte_mode = 1'b0;
   assign byte_hi   = 1'b0;
   assign byte_sext = 1'b0;
`endif

   assign mem_sel  = (sel == SELW'(MEM_SRC));
   assign byte_val = byte_hi ? sel_value[15:8] : sel_value[7:0];

   always_comb begin
      wb_value = sel_value;
      if (mem_sel && byte_mode) begin
         wb_value = {{(WIDTH-8){byte_sext & byte_val[7]}}, byte_val};
      end
   end

   assign pl_in = {in_wr_en, in_wr_addr, wb_value};

   wb_skid_buf #(
      .PW (PW)
   ) u_skid (
      .clk_i       (clk),
      .reset_ni    (reset),
      .in_data_i   (pl_in),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (pl_out),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   assign {pl_we, out_wr_addr, out_data} = pl_out;
   // a drained stale entry must never request a register write
   assign out_wr_en = pl_we & out_valid;

endmodule

// File: tb/tb_wb_select_pipe.sv
module tb_wb_select_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [15:0] srcs [4];
   logic [1:0]  sel;
   logic [3:0]  in_wr_addr;
   logic        in_wr_en, in_valid, out_ready;
`ifdef WB_BYTE_LOAD_EN
   logic        ld_byte, ld_hi, ld_signed;
`endif

   logic [63:0] src4;
   logic [47:0] src3;
   assign src4 = {srcs[3], srcs[2], srcs[1], srcs[0]};
   assign src3 = {srcs[2], srcs[1], srcs[0]};

   logic        in_ready, out_wr_en, out_valid;
   logic [15:0] out_data;
   logic [3:0]  out_wr_addr;
   logic        in_ready3, out_wr_en3, out_valid3;
   logic [15:0] out_data3;
   logic [3:0]  out_wr_addr3;

   wb_select_pipe #(.WIDTH(16), .NSRC(4), .SELW(2), .AW(4), .MEM_SRC(1)) dut (
      .clk(clk), .reset(reset), .src_data(src4), .sel(sel),
      .in_wr_addr(in_wr_addr), .in_wr_en(in_wr_en), .in_valid(in_valid),
      .in_ready(in_ready),
`ifdef WB_BYTE_LOAD_EN
      .ld_byte(ld_byte), .ld_hi(ld_hi), .ld_signed(ld_signed),
`endif
      .out_data(out_data), .out_wr_addr(out_wr_addr), .out_wr_en(out_wr_en),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   wb_select_pipe #(.WIDTH(16), .NSRC(3), .SELW(2), .AW(4), .MEM_SRC(1)) dut3 (
      .clk(clk), .reset(reset), .src_data(src3), .sel(sel),
      .in_wr_addr(in_wr_addr), .in_wr_en(in_wr_en), .in_valid(in_valid),
      .in_ready(in_ready3),
`ifdef WB_BYTE_LOAD_EN
      .ld_byte(ld_byte), .ld_hi(ld_hi), .ld_signed(ld_signed),
`endif
      .out_data(out_data3), .out_wr_addr(out_wr_addr3), .out_wr_en(out_wr_en3),
      .out_valid(out_valid3), .out_ready(out_ready)
   );

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  a;
      logic        we;
   } ent_t;

   ent_t q4[$];
   ent_t q3[$];
   bit   rdy_exp;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Value the writeback stage should register for a given source count
   function automatic logic [15:0] pick(input int nsrc);
      int          idx;
      logic [15:0] v;
      logic [7:0]  b;
      idx = (int'(sel) < nsrc) ? int'(sel) : 0;
      v   = srcs[idx];
      b   = 8'h00;
`ifdef WB_BYTE_LOAD_EN
      if (idx == 1 && ld_byte) begin
         b = ld_hi ? v[15:8] : v[7:0];
         v = ld_signed ? {{8{b[7]}}, b} : {8'h00, b};
      end
`endif
      return v | {8'h00, b & 8'h00};
   endfunction

   task automatic check_outputs();
      chk("in_ready", in_ready, rdy_exp);
      chk("in_ready3", in_ready3, rdy_exp);
      chk("out_valid", out_valid, q4.size() != 0);
      chk("out_valid3", out_valid3, q3.size() != 0);
      if (q4.size() != 0) begin
         chk("out_data", out_data, q4[0].d);
         chk("out_wr_addr", out_wr_addr, q4[0].a);
         chk("out_wr_en", out_wr_en, q4[0].we);
         chk("out_data3", out_data3, q3[0].d);
         chk("out_wr_en3", out_wr_en3, q3[0].we);
      end else begin
         chk("out_wr_en_idle", out_wr_en, 1'b0);
         chk("out_wr_en3_idle", out_wr_en3, 1'b0);
      end
   endtask

   // One clock: update the FIFO model at the edge, then check at negedge
   task automatic tick();
      bit   acc, drn;
      ent_t e4, e3;
      @(posedge clk);
      if (!reset) begin
         q4.delete();
         q3.delete();
         rdy_exp = 1'b0;
      end else begin
         acc = in_valid && rdy_exp;
         drn = (q4.size() != 0) && out_ready;
         e4  = '{d: pick(4), a: in_wr_addr, we: in_wr_en};
         e3  = '{d: pick(3), a: in_wr_addr, we: in_wr_en};
         if (drn) begin
            void'(q4.pop_front());
            void'(q3.pop_front());
         end
         if (acc) begin
            q4.push_back(e4);
            q3.push_back(e3);
         end
         rdy_exp = (q4.size() < 2);
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic randomize_srcs();
      for (int i = 0; i < 4; i++) srcs[i] = 16'($urandom);
   endtask

   initial begin
      int consec;
      reset      = 1'b0;
      sel        = 2'd0;
      in_wr_addr = 4'h0;
      in_wr_en   = 1'b1;
      in_valid   = 1'b1;
      out_ready  = 1'b0;
`ifdef WB_BYTE_LOAD_EN
      ld_byte = 1'b0; ld_hi = 1'b0; ld_signed = 1'b0;
`endif
      randomize_srcs();
      rdy_exp = 1'b0;

      // reset held two cycles with in_valid high
      @(negedge clk);
      tick();
      tick();
      chk("rst_out_data", out_data, 16'h0000);
      chk("rst_out_wr_addr", out_wr_addr, 4'h0);
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("rst_release_ready", in_ready, 1'b1);

      // select LINK
      srcs[0] = 16'h1111; srcs[1] = 16'h2222; srcs[2] = 16'h3333; srcs[3] = 16'h4444;
      sel = 2'd2; in_wr_addr = 4'h5; in_wr_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("sel_link", out_data, 16'h3333);
      chk("sel_link_addr", out_wr_addr, 4'h5);
      // sel=3: IMM on the 4-source build, falls back to ALU on the 3-source build
      sel = 2'd3; in_wr_en = 1'b0;
      tick();
      chk("sel_imm", out_data, 16'h4444);
      chk("sel_oob_alu", out_data3, 16'h1111);
      in_valid = 1'b0;
      tick();

      // stall / skid
      out_ready = 1'b0; sel = 2'd0; in_wr_en = 1'b1;
      srcs[0] = 16'hAAAA; in_wr_addr = 4'hA; in_valid = 1'b1;
      tick();
      srcs[0] = 16'hBBBB; in_wr_addr = 4'hB;
      tick();
      in_valid = 1'b0;
      tick();
      chk("stall_ready_low", in_ready, 1'b0);
      chk("stall_hold_a", out_data, 16'hAAAA);
      out_ready = 1'b1;
      tick();
      chk("drain_b", out_data, 16'hBBBB);
      tick();
      chk("drain_empty", out_valid, 1'b0);

      // throughput: 8 back-to-back entries
      consec = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         randomize_srcs();
         sel = 2'($urandom); in_wr_addr = 4'(i);
         tick();
         if (out_valid && out_wr_addr == 4'(i)) consec++;
      end
      in_valid = 1'b0;
      tick();
      chk("throughput_consec", consec, 8);

      // reset while full
      out_ready = 1'b0; in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      reset = 1'b0;
      tick();
      chk("midrst_valid", out_valid, 1'b0);
      reset = 1'b1;
      tick();
      srcs[0] = 16'h5A5A; sel = 2'd0; in_wr_addr = 4'h7; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("midrst_single", out_data, 16'h5A5A);
      in_valid = 1'b0;
      tick();

`ifdef WB_BYTE_LOAD_EN
      srcs[1] = 16'h80F7; sel = 2'd1; in_valid = 1'b1;
      ld_byte = 1'b1; ld_hi = 1'b0; ld_signed = 1'b1;
      tick();
      chk("byte_lo_sext", out_data, 16'hFFF7);
      ld_hi = 1'b1; ld_signed = 1'b0;
      tick();
      chk("byte_hi_zext", out_data, 16'h0080);
      in_valid = 1'b0; ld_byte = 1'b0;
      tick();
`endif

      // randomized traffic against the FIFO model
      for (int i = 0; i < 400; i++) begin
         randomize_srcs();
         sel        = 2'($urandom);
         in_wr_addr = 4'($urandom);
         in_wr_en   = 1'($urandom);
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         reset      = ($urandom_range(0, 49) != 0);
`ifdef WB_BYTE_LOAD_EN
         ld_byte = 1'($urandom); ld_hi = 1'($urandom); ld_signed = 1'($urandom);
`endif
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
